// File: rtl/arch_defs_pkg.sv
// Shared architectural definitions: datapath width and ALU operation encodings.
// The legacy 3-bit ALU op codes are kept alongside the sequential ALU's 4-bit set.
package arch_defs_pkg;

  localparam int unsigned DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    AluAdd = 3'd0,
    AluSub = 3'd1,
    AluAnd = 3'd2,
    AluOr  = 3'd3,
    AluXor = 3'd4,
    AluNot = 3'd5,
    AluShl = 3'd6,
    AluShr = 3'd7
  } alu_op_t;

  typedef enum logic [3:0] {
    OpAdd = 4'd0,
    OpAdc = 4'd1,
    OpSub = 4'd2,
    OpSbc = 4'd3,
    OpInr = 4'd4,
    OpDcr = 4'd5,
    OpAnd = 4'd6,
    OpOr  = 4'd7,
    OpXor = 4'd8,
    OpNot = 4'd9,
    OpShl = 4'd10,
    OpShr = 4'd11,
    OpRol = 4'd12,
    OpRor = 4'd13,
    OpMul = 4'd14,
    OpCmp = 4'd15
  } alu_seq_op_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle of the sequential ALU; master issues ops, slave is the ALU.
interface alu_seq_if
  import arch_defs_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) ();

  logic             op_valid;
  logic             op_ready;
  alu_seq_op_t      alu_op;
  logic [WIDTH-1:0] in_one;
  logic [WIDTH-1:0] in_two;
  logic             in_carry;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             result_valid;
  logic             zero_flag;
  logic             carry_flag;
  logic             negative_flag;
  logic             overflow_flag;

  modport master (
    output op_valid, alu_op, in_one, in_two, in_carry,
    input  op_ready, result, result_hi, result_valid,
    input  zero_flag, carry_flag, negative_flag, overflow_flag
  );

  modport slave (
    input  op_valid, alu_op, in_one, in_two, in_carry,
    output op_ready, result, result_hi, result_valid,
    output zero_flag, carry_flag, negative_flag, overflow_flag
  );

endinterface

// File: rtl/mul_shift_add.sv
// Unsigned iterative shift-add multiplier: one partial product per cycle, WIDTH cycles.
// product_o is the final product only while done_o is high (the last iteration).
module mul_shift_add
  import arch_defs_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [CntW-1:0]    cnt_q;
  logic               busy_q;

  assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done_o    = busy_q && (cnt_q == CntW'(WIDTH - 1));
  assign busy_o    = busy_q;
  assign product_o = acc_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start_i && !busy_q) begin
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      mplier_q <= b_i;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (done_o) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic/shift ops, multi-cycle MUL via
// the shift-add sub-module. All results and flags are registered.
module alu_seq
  import arch_defs_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input logic     clk,
  input logic     reset,
  alu_seq_if.slave bus
);

  localparam int unsigned Msb = WIDTH - 1;

  typedef enum logic [0:0] {StIdle, StMulRun} state_e;

  state_e             state_q;
  logic               ready_q;
  logic               valid_q;
  logic [WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]   result_hi_q;
  logic               zero_q, carry_q, neg_q, ovf_q;

  logic [WIDTH-1:0]   a, b_eff;
  logic               cin_eff;
  logic [WIDTH:0]     sum;
  logic               arith_v;
  logic [WIDTH-1:0]   alu_res, flag_src;
  logic               alu_c, alu_v;
  logic               accept, mul_start;
  logic               mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_product;

  assign a         = bus.in_one;
  assign accept    = bus.op_valid && ready_q && (state_q == StIdle);
  assign mul_start = accept && (bus.alu_op == OpMul);

  // One shared WIDTH+1 adder; subtracts use a + ~b + cin so carry = no-borrow.
  always_comb begin
    b_eff   = bus.in_two;
    cin_eff = 1'b0;
    unique case (bus.alu_op)
      OpAdc:        cin_eff = bus.in_carry;
      OpSub, OpCmp: begin b_eff = ~bus.in_two; cin_eff = 1'b1; end
      OpSbc:        begin b_eff = ~bus.in_two; cin_eff = bus.in_carry; end
      OpInr:        begin b_eff = '0;          cin_eff = 1'b1; end
      OpDcr:        b_eff = '1;
      default:      ;
    endcase
  end

  assign sum     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_eff};
  assign arith_v = (a[Msb] == b_eff[Msb]) && (sum[Msb] != a[Msb]);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (bus.alu_op)
      OpAdd, OpAdc, OpSub, OpSbc, OpInr, OpDcr: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = arith_v;
      end
      OpAnd: alu_res = a & bus.in_two;
      OpOr:  alu_res = a | bus.in_two;
      OpXor: alu_res = a ^ bus.in_two;
      OpNot: alu_res = ~a;
      OpShl: begin alu_res = {a[Msb-1:0], 1'b0};         alu_c = a[Msb]; end
      OpShr: begin alu_res = {1'b0, a[Msb:1]};           alu_c = a[0];   end
      OpRol: begin alu_res = {a[Msb-1:0], bus.in_carry}; alu_c = a[Msb]; end
      OpRor: begin alu_res = {bus.in_carry, a[Msb:1]};   alu_c = a[0];   end
      OpCmp: begin
        alu_res = a;
        alu_c   = sum[WIDTH];
        alu_v   = arith_v;
      end
      OpMul: ;
    endcase
  end

  // CMP reports Z/N of the difference while returning in_one unchanged.
  assign flag_src = (bus.alu_op == OpCmp) ? sum[WIDTH-1:0] : alu_res;

  mul_shift_add #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk      (clk),
    .reset    (reset),
    .start_i  (mul_start),
    .a_i      (bus.in_one),
    .b_i      (bus.in_two),
    .busy_o   (mul_busy),
    .done_o   (mul_done),
    .product_o(mul_product)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (mul_start) begin
            state_q <= StMulRun;
            ready_q <= 1'b0;
          end else if (accept) begin
            result_q    <= alu_res;
            result_hi_q <= '0;
            zero_q      <= (flag_src == '0);
            carry_q     <= alu_c;
            neg_q       <= flag_src[Msb];
            ovf_q       <= alu_v;
            valid_q     <= 1'b1;
          end
        end
        StMulRun: begin
          if (mul_done) begin
            result_q    <= mul_product[WIDTH-1:0];
            result_hi_q <= mul_product[2*WIDTH-1:WIDTH];
            zero_q      <= (mul_product == '0);
            carry_q     <= (mul_product[2*WIDTH-1:WIDTH] != '0);
            neg_q       <= mul_product[Msb];
            ovf_q       <= 1'b0;
            valid_q     <= 1'b1;
            ready_q     <= 1'b1;
            state_q     <= StIdle;
          end else if (!mul_busy) begin
            // Multiplier lost its run without finishing; recover to idle.
            ready_q <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.op_ready      = ready_q;
  assign bus.result        = result_q;
  assign bus.result_hi     = result_hi_q;
  assign bus.result_valid  = valid_q;
  assign bus.zero_flag     = zero_q;
  assign bus.carry_flag    = carry_q;
  assign bus.negative_flag = neg_q;
  assign bus.overflow_flag = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: vector table through a scoreboard, plus
// hand-written MUL busy and mid-MUL reset sequences.
module tb_alu_seq;
  import arch_defs_pkg::*;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(
    .WIDTH(W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [7:0] res;
    logic [7:0] hi;
    logic [3:0] flags;  // {Z, C, N, V}
    int         due;
  } exp_t;

  typedef struct {
    alu_seq_op_t op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        cin;
    logic [7:0]  res;
    logic [7:0]  hi;
    logic [3:0]  flags;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];
  exp_t sb [$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] dut_flags();
    return {bus.zero_flag, bus.carry_flag, bus.negative_flag, bus.overflow_flag};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every result_valid pulse must match the oldest outstanding op.
  always begin
    @(posedge clk);
    #1;
    if (bus.result_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result_valid: got pulse at cycle %0d expected none", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("result", 32'(bus.result), 32'(mon_e.res));
        check("result_hi", 32'(bus.result_hi), 32'(mon_e.hi));
        check("flags_zcnv", 32'(dut_flags()), 32'(mon_e.flags));
        check("completion_cycle", 32'(cyc), 32'(mon_e.due));
      end
    end
  end

  task automatic issue(input alu_seq_op_t op, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic [7:0] res, input logic [7:0] hi,
                       input logic [3:0] flags, input bit push);
    int   w;
    exp_t e;
    w = 0;
    @(negedge clk);
    while (bus.op_ready !== 1'b1 && w < 100) begin
      bus.op_valid = 1'b0;
      @(negedge clk);
      w++;
    end
    if (w >= 100) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got op_ready low for %0d cycles expected high", w);
    end
    bus.op_valid = 1'b1;
    bus.alu_op   = op;
    bus.in_one   = a;
    bus.in_two   = b;
    bus.in_carry = cin;
    if (push) begin
      e.res   = res;
      e.hi    = hi;
      e.flags = flags;
      e.due   = cyc + 1 + ((op == OpMul) ? int'(W) : 0);
      sb.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.op_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    int low;
    vecs[0]  = '{OpAdd, 8'h7F, 8'h01, 1'b0, 8'h80, 8'h00, 4'b0011};
    vecs[1]  = '{OpSub, 8'h05, 8'h07, 1'b0, 8'hFE, 8'h00, 4'b0010};
    vecs[2]  = '{OpSub, 8'h07, 8'h05, 1'b0, 8'h02, 8'h00, 4'b0100};
    vecs[3]  = '{OpRol, 8'h81, 8'h00, 1'b0, 8'h02, 8'h00, 4'b0100};
    vecs[4]  = '{OpRor, 8'h01, 8'h00, 1'b1, 8'h80, 8'h00, 4'b0110};
    vecs[5]  = '{OpXor, 8'hAA, 8'hAA, 1'b0, 8'h00, 8'h00, 4'b1000};
    vecs[6]  = '{OpCmp, 8'h10, 8'h10, 1'b0, 8'h10, 8'h00, 4'b1100};
    vecs[7]  = '{OpAdc, 8'hFF, 8'h00, 1'b1, 8'h00, 8'h00, 4'b1100};
    vecs[8]  = '{OpSbc, 8'h10, 8'h01, 1'b0, 8'h0E, 8'h00, 4'b0100};
    vecs[9]  = '{OpInr, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, 4'b1100};
    vecs[10] = '{OpDcr, 8'h00, 8'h00, 1'b0, 8'hFF, 8'h00, 4'b0010};
    vecs[11] = '{OpDcr, 8'h80, 8'h00, 1'b0, 8'h7F, 8'h00, 4'b0101};
    vecs[12] = '{OpAnd, 8'hF0, 8'h3C, 1'b1, 8'h30, 8'h00, 4'b0000};
    vecs[13] = '{OpOr,  8'h80, 8'h01, 1'b0, 8'h81, 8'h00, 4'b0010};
    vecs[14] = '{OpNot, 8'h0F, 8'h00, 1'b0, 8'hF0, 8'h00, 4'b0010};
    vecs[15] = '{OpShl, 8'h81, 8'h00, 1'b1, 8'h02, 8'h00, 4'b0100};
    vecs[16] = '{OpShr, 8'h81, 8'h00, 1'b1, 8'h40, 8'h00, 4'b0100};
    vecs[17] = '{OpSub, 8'h80, 8'h01, 1'b0, 8'h7F, 8'h00, 4'b0101};
    vecs[18] = '{OpAdd, 8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 4'b1100};
    vecs[19] = '{OpCmp, 8'h05, 8'h07, 1'b0, 8'h05, 8'h00, 4'b0010};
    vecs[20] = '{OpMul, 8'h10, 8'h10, 1'b0, 8'h00, 8'h01, 4'b0100};
    vecs[21] = '{OpMul, 8'h00, 8'h37, 1'b0, 8'h00, 8'h00, 4'b1000};
    vecs[22] = '{OpSbc, 8'h05, 8'h05, 1'b0, 8'hFF, 8'h00, 4'b0010};
    vecs[23] = '{OpAdc, 8'h01, 8'h01, 1'b0, 8'h02, 8'h00, 4'b0000};

    bus.op_valid = 1'b0;
    bus.alu_op   = OpAdd;
    bus.in_one   = '0;
    bus.in_two   = '0;
    bus.in_carry = 1'b0;
    reset        = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_result", 32'(bus.result), 32'h0);
    check("reset_result_hi", 32'(bus.result_hi), 32'h0);
    check("reset_flags", 32'(dut_flags()), 32'h0);
    check("reset_result_valid", 32'(bus.result_valid), 32'h0);
    check("reset_op_ready", 32'(bus.op_ready), 32'h1);

    // Back-to-back table; MUL entries stall the following op until ready.
    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].res, vecs[i].hi,
            vecs[i].flags, 1'b1);
    end
    idle();
    repeat (3) @(negedge clk);

    // MUL 0xFF*0xFF with op_valid held high through the busy window.
    issue(OpMul, 8'hFF, 8'hFF, 1'b0, 8'h01, 8'hFE, 4'b0100, 1'b1);
    low = 0;
    @(negedge clk);
    while (bus.op_ready !== 1'b1 && low < 40) begin
      low++;
      bus.op_valid = 1'b1;
      bus.alu_op   = OpAdd;
      bus.in_one   = 8'h01;
      bus.in_two   = 8'h01;
      @(negedge clk);
    end
    bus.op_valid = 1'b0;
    check("mul_ready_low_cycles", 32'(low), 32'(W));
    repeat (3) @(negedge clk);

    // Reset during the third MUL_RUN cycle: no completion, outputs cleared.
    issue(OpMul, 8'h12, 8'h34, 1'b0, 8'h00, 8'h00, 4'b0000, 1'b0);
    @(negedge clk);
    bus.op_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_result", 32'(bus.result), 32'h0);
    check("abort_result_hi", 32'(bus.result_hi), 32'h0);
    check("abort_flags", 32'(dut_flags()), 32'h0);
    check("abort_result_valid", 32'(bus.result_valid), 32'h0);
    check("abort_op_ready", 32'(bus.op_ready), 32'h1);
    repeat (12) @(negedge clk);
    issue(OpAdd, 8'h02, 8'h03, 1'b0, 8'h05, 8'h00, 4'b0000, 1'b1);
    idle();
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
